// File: rtl/player_move_fsm_pkg.sv
// Shared movement package: player movement state, physics defaults, vector widths,
// and the animation-stage art lookup that consumes movement_state.
package player_move_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        JUMP = 2'd2,
        FALL = 2'd3
    } movement_state;

    // Art sets available to the animation stage.
    typedef enum logic [1:0] {
        ART_IDLE = 2'd0,
        ART_WALK = 2'd1
    } anim_art;

    localparam int unsigned POS_W  = 11;  // screen coordinate width
    localparam int unsigned VY_W   = 5;   // vertical speed magnitude
    localparam int unsigned VERT_W = 12;  // headroom for add-then-compare

    localparam int unsigned DEF_START_X    = 296;
    localparam int unsigned DEF_GROUND_Y   = 400;
    localparam int unsigned DEF_X_MAX      = 592;
    localparam int unsigned DEF_WALK_SPEED = 2;
    localparam int unsigned DEF_JUMP_VEL   = 12;
    localparam int unsigned DEF_MAX_FALL   = 12;

    // JUMP/FALL have no dedicated art yet, so they borrow the idle frames.
    function automatic anim_art anim_art_sel(input movement_state st);
        anim_art art;
        art = ART_IDLE;
        if (st == WALK) art = ART_WALK;
        return art;
    endfunction

endpackage

// File: rtl/player_move_fsm_if.sv
// Player movement bus: per-frame strobe and buttons in, sprite state out.
//   master: frame_tick, btn_left, btn_right, btn_jump -> ; <- move_state, pos_x, pos_y, facing_left, grounded
//   slave : the mirror image, used by player_move_fsm.
interface player_move_fsm_if;
    import player_move_fsm_pkg::*;

    logic              frame_tick;
    logic              btn_left;
    logic              btn_right;
    logic              btn_jump;
    movement_state     move_state;
    logic [POS_W-1:0]  pos_x;
    logic [POS_W-1:0]  pos_y;
    logic              facing_left;
    logic              grounded;

    modport master (
        output frame_tick, btn_left, btn_right, btn_jump,
        input  move_state, pos_x, pos_y, facing_left, grounded
    );

    modport slave (
        input  frame_tick, btn_left, btn_right, btn_jump,
        output move_state, pos_x, pos_y, facing_left, grounded
    );
endinterface

// File: rtl/player_move_fsm.sv
// Player movement FSM: walks, jumps and falls a sprite once per frame_tick.
// Ports:
//   clk   - system clock, all state on posedge
//   reset - synchronous active-high reset, wins over frame_tick
//   bus   - player_move_fsm_if.slave: frame_tick/buttons in; move_state, pos_x,
//           pos_y, facing_left, grounded out (all registered)
module player_move_fsm
    import player_move_fsm_pkg::*;
#(
    parameter int unsigned START_X    = DEF_START_X,
    parameter int unsigned GROUND_Y   = DEF_GROUND_Y,
    parameter int unsigned X_MAX      = DEF_X_MAX,
    parameter int unsigned WALK_SPEED = DEF_WALK_SPEED,
    parameter int unsigned JUMP_VEL   = DEF_JUMP_VEL,
    parameter int unsigned MAX_FALL   = DEF_MAX_FALL
) (
    input  logic               clk,
    input  logic               reset,
    player_move_fsm_if.slave   bus
);

    localparam logic [VERT_W-1:0] GROUND_V = VERT_W'(GROUND_Y);
    localparam logic [VERT_W-1:0] X_MAX_V  = VERT_W'(X_MAX);
    localparam logic [VERT_W-1:0] WALK_V   = VERT_W'(WALK_SPEED);
    localparam logic [VY_W-1:0]   JUMP_VY  = VY_W'(JUMP_VEL);
    localparam logic [VY_W-1:0]   FALL_VY  = VY_W'(MAX_FALL);

    movement_state     state_q, state_d;
    logic [POS_W-1:0]  pos_x_q, pos_x_d;
    logic [POS_W-1:0]  pos_y_q, pos_y_d;
    logic [VY_W-1:0]   vy_q, vy_d;
    logic              facing_q, facing_d;
    logic              grounded_q, grounded_d;
    logic              jump_prev_q;

    logic              go_left;
    logic              go_right;
    logic              move;
    logic              jump_edge;
    logic [VERT_W-1:0] x_wide;
    logic [VERT_W-1:0] y_wide;
    logic [VERT_W-1:0] x_sum;
    logic [VERT_W-1:0] y_sum;
    logic [VY_W-1:0]   vy_dec;
    logic [VY_W-1:0]   vy_fall;

    // Next-state, position and velocity for the coming frame_tick.
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        vy_d       = vy_q;
        facing_d   = facing_q;

        go_left    = bus.btn_left & ~bus.btn_right;
        go_right   = bus.btn_right & ~bus.btn_left;
        move       = go_left | go_right;
        jump_edge  = bus.btn_jump & ~jump_prev_q;

        x_wide     = VERT_W'(pos_x_q);
        y_wide     = VERT_W'(pos_y_q);
        x_sum      = x_wide + WALK_V;
        vy_dec     = (vy_q == '0) ? '0 : vy_q - VY_W'(1);
        vy_fall    = (vy_q < FALL_VY) ? vy_q + VY_W'(1) : FALL_VY;
        y_sum      = y_wide + VERT_W'(vy_fall);

        // Horizontal motion applies in every state, including airborne.
        if (go_left) begin
            pos_x_d  = (x_wide < WALK_V) ? '0 : POS_W'(x_wide - WALK_V);
            facing_d = 1'b1;
        end else if (go_right) begin
            pos_x_d  = (x_sum > X_MAX_V) ? POS_W'(X_MAX_V) : POS_W'(x_sum);
            facing_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (jump_edge) begin
                    state_d = JUMP;
                    vy_d    = JUMP_VY;
                end else if (move) begin
                    state_d = WALK;
                end
            end
            WALK: begin
                if (jump_edge) begin
                    state_d = JUMP;
                    vy_d    = JUMP_VY;
                end else if (!move) begin
                    state_d = IDLE;
                end
            end
            JUMP: begin
                pos_y_d = POS_W'(y_wide - VERT_W'(vy_q));
                vy_d    = vy_dec;
                if (vy_dec == '0) state_d = FALL;
            end
            FALL: begin
                // Clamp to the floor so the sprite never sinks below it.
                if (y_sum >= GROUND_V) begin
                    pos_y_d = POS_W'(GROUND_V);
                    vy_d    = '0;
                    state_d = move ? WALK : IDLE;
                end else begin
                    pos_y_d = POS_W'(y_sum);
                    vy_d    = vy_fall;
                end
            end
            default: state_d = IDLE;
        endcase

        grounded_d = (state_d == IDLE) || (state_d == WALK);
    end

    // State and output registers, advanced only on frame_tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pos_x_q     <= POS_W'(START_X);
            pos_y_q     <= POS_W'(GROUND_Y);
            vy_q        <= '0;
            facing_q    <= 1'b0;
            grounded_q  <= 1'b1;
            jump_prev_q <= 1'b0;
        end else if (bus.frame_tick) begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            vy_q        <= vy_d;
            facing_q    <= facing_d;
            grounded_q  <= grounded_d;
            jump_prev_q <= bus.btn_jump;
        end
    end

    assign bus.move_state  = state_q;
    assign bus.pos_x       = pos_x_q;
    assign bus.pos_y       = pos_y_q;
    assign bus.facing_left = facing_q;
    assign bus.grounded    = grounded_q;

endmodule

// File: tb/tb_player_move_fsm.sv
// Bench for player_move_fsm: a reference model pushes the expected outputs of every
// frame_tick into a queue; a monitor pops and compares after the DUT updates.
// Scenario tasks add direct checks against the documented trajectory values.
module tb_player_move_fsm;
    import player_move_fsm_pkg::*;

    typedef struct {
        movement_state st;
        int            x;
        int            y;
        bit            face;
        bit            gnd;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    player_move_fsm_if bus();
    player_move_fsm_if edge_bus();

    player_move_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    player_move_fsm #(.START_X(1)) dut_edge (
        .clk   (clk),
        .reset (reset),
        .bus   (edge_bus)
    );

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    movement_state m_state;
    int m_x, m_y, m_vy;
    bit m_face, m_prev;

    function automatic void model_reset();
        m_state = IDLE;
        m_x     = int'(DEF_START_X);
        m_y     = int'(DEF_GROUND_Y);
        m_vy    = 0;
        m_face  = 1'b0;
        m_prev  = 1'b0;
    endfunction

    function automatic void model_step(input bit l, input bit r, input bit j);
        bit go_l, go_r, edge_j;
        int vn;
        go_l   = l && !r;
        go_r   = r && !l;
        edge_j = j && !m_prev;
        m_prev = j;
        if (go_l) begin
            m_x    = (m_x >= 2) ? m_x - 2 : 0;
            m_face = 1'b1;
        end else if (go_r) begin
            m_x    = (m_x + 2 > 592) ? 592 : m_x + 2;
            m_face = 1'b0;
        end
        case (m_state)
            IDLE: begin
                if (edge_j) begin m_state = JUMP; m_vy = 12; end
                else if (go_l || go_r) m_state = WALK;
            end
            WALK: begin
                if (edge_j) begin m_state = JUMP; m_vy = 12; end
                else if (!(go_l || go_r)) m_state = IDLE;
            end
            JUMP: begin
                m_y  = m_y - m_vy;
                m_vy = m_vy - 1;
                if (m_vy == 0) m_state = FALL;
            end
            default: begin
                vn = (m_vy + 1 > 12) ? 12 : m_vy + 1;
                if (m_y + vn >= 400) begin
                    m_y     = 400;
                    m_vy    = 0;
                    m_state = (go_l || go_r) ? WALK : IDLE;
                end else begin
                    m_y  = m_y + vn;
                    m_vy = vn;
                end
            end
        endcase
    endfunction

    // One frame_tick on the main DUT; expectation queued as the stimulus is driven.
    task automatic tick(input bit l, input bit r, input bit j);
        exp_t e;
        @(negedge clk);
        bus.btn_left   = l;
        bus.btn_right  = r;
        bus.btn_jump   = j;
        bus.frame_tick = 1'b1;
        model_step(l, r, j);
        e.st   = m_state;
        e.x    = m_x;
        e.y    = m_y;
        e.face = m_face;
        e.gnd  = (m_state == IDLE) || (m_state == WALK);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
    endtask

    task automatic do_reset(input bit with_tick, input bit jump_held);
        @(negedge clk);
        reset          = 1'b1;
        bus.frame_tick = with_tick;
        bus.btn_jump   = jump_held;
        model_reset();
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.btn_jump   = 1'b0;
    endtask

    // Scoreboard: compare every non-reset frame_tick result against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (bus.frame_tick === 1'b1 && reset === 1'b0) begin
                #1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty got an update with no expectation queued");
                end else begin
                    e = exp_q.pop_front();
                    if (bus.move_state !== e.st || bus.pos_x !== 11'(e.x) || bus.pos_y !== 11'(e.y) ||
                        bus.facing_left !== e.face || bus.grounded !== e.gnd) begin
                        failures++;
                        $display("FAIL sb_tick got st=%0d x=%0d y=%0d face=%0b gnd=%0b exp st=%0d x=%0d y=%0d face=%0b gnd=%0b",
                                 bus.move_state, bus.pos_x, bus.pos_y, bus.facing_left, bus.grounded,
                                 e.st, e.x, e.y, e.face, e.gnd);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        do_reset(1'b0, 1'b0);
        checks++;
        if (bus.move_state !== IDLE || bus.pos_x !== 11'd296 || bus.pos_y !== 11'd400 ||
            bus.grounded !== 1'b1 || bus.facing_left !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got st=%0d x=%0d y=%0d gnd=%0b face=%0b exp st=0 x=296 y=400 gnd=1 face=0",
                     bus.move_state, bus.pos_x, bus.pos_y, bus.grounded, bus.facing_left);
        end
        for (int t = 1; t <= 10; t++) begin
            tick(1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.move_state !== IDLE || bus.grounded !== 1'b1 ||
                bus.pos_x !== 11'd296 || bus.pos_y !== 11'd400) begin
                failures++;
                $display("FAIL idle_hold t=%0d got st=%0d gnd=%0b x=%0d y=%0d exp st=0 gnd=1 x=296 y=400",
                         t, bus.move_state, bus.grounded, bus.pos_x, bus.pos_y);
            end
        end
    endtask

    task automatic test_walk();
        do_reset(1'b0, 1'b0);
        for (int t = 1; t <= 5; t++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (t == 1) begin
                checks++;
                if (bus.move_state !== WALK) begin
                    failures++;
                    $display("FAIL walk_enter got st=%0d exp st=%0d", bus.move_state, WALK);
                end
            end
        end
        checks++;
        if (bus.pos_x !== 11'd306 || bus.facing_left !== 1'b0) begin
            failures++;
            $display("FAIL walk_right got x=%0d face=%0b exp x=306 face=0", bus.pos_x, bus.facing_left);
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.move_state !== IDLE || bus.pos_x !== 11'd306) begin
            failures++;
            $display("FAIL walk_release got st=%0d x=%0d exp st=0 x=306", bus.move_state, bus.pos_x);
        end
        // Walk into the right wall.
        for (int t = 0; t < 160; t++) tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.pos_x !== 11'd592) begin
            failures++;
            $display("FAIL right_sat got x=%0d exp x=592", bus.pos_x);
        end
        tick(1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.pos_x !== 11'd592 || bus.facing_left !== 1'b0 || bus.move_state !== IDLE) begin
            failures++;
            $display("FAIL both_btn got x=%0d face=%0b st=%0d exp x=592 face=0 st=0",
                     bus.pos_x, bus.facing_left, bus.move_state);
        end
    endtask

    task automatic edge_tick(input bit l, input bit r);
        @(negedge clk);
        edge_bus.btn_left   = l;
        edge_bus.btn_right  = r;
        edge_bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        edge_bus.frame_tick = 1'b0;
    endtask

    task automatic test_left_edge();
        do_reset(1'b0, 1'b0);
        checks++;
        if (edge_bus.pos_x !== 11'd1) begin
            failures++;
            $display("FAIL edge_reset got x=%0d exp x=1", edge_bus.pos_x);
        end
        edge_tick(1'b1, 1'b0);
        checks++;
        if (edge_bus.pos_x !== 11'd0 || edge_bus.facing_left !== 1'b1) begin
            failures++;
            $display("FAIL left_sat1 got x=%0d face=%0b exp x=0 face=1", edge_bus.pos_x, edge_bus.facing_left);
        end
        edge_tick(1'b1, 1'b0);
        checks++;
        if (edge_bus.pos_x !== 11'd0) begin
            failures++;
            $display("FAIL left_sat2 got x=%0d exp x=0", edge_bus.pos_x);
        end
        edge_tick(1'b1, 1'b1);
        checks++;
        if (edge_bus.pos_x !== 11'd0 || edge_bus.facing_left !== 1'b1) begin
            failures++;
            $display("FAIL edge_both got x=%0d face=%0b exp x=0 face=1", edge_bus.pos_x, edge_bus.facing_left);
        end
        edge_bus.btn_left  = 1'b0;
        edge_bus.btn_right = 1'b0;
    endtask

    task automatic test_jump();
        do_reset(1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.move_state !== JUMP || bus.pos_y !== 11'd400 || bus.grounded !== 1'b0) begin
            failures++;
            $display("FAIL jump_launch got st=%0d y=%0d gnd=%0b exp st=%0d y=400 gnd=0",
                     bus.move_state, bus.pos_y, bus.grounded, JUMP);
        end
        // Button held through the whole arc and beyond: exactly one jump.
        for (int t = 1; t <= 28; t++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (t == 1) begin
                checks++;
                if (bus.pos_y !== 11'd388 || bus.move_state !== JUMP) begin
                    failures++;
                    $display("FAIL jump_t1 got y=%0d st=%0d exp y=388 st=%0d", bus.pos_y, bus.move_state, JUMP);
                end
            end else if (t == 12) begin
                checks++;
                if (bus.pos_y !== 11'd322 || bus.move_state !== FALL) begin
                    failures++;
                    $display("FAIL jump_apex got y=%0d st=%0d exp y=322 st=%0d", bus.pos_y, bus.move_state, FALL);
                end
            end else if (t >= 24) begin
                checks++;
                if (bus.pos_y !== 11'd400 || bus.move_state !== IDLE || bus.grounded !== 1'b1) begin
                    failures++;
                    $display("FAIL jump_land t=%0d got y=%0d st=%0d gnd=%0b exp y=400 st=0 gnd=1",
                             t, bus.pos_y, bus.move_state, bus.grounded);
                end
            end
        end
    endtask

    task automatic test_jump_walk();
        logic [10:0] x0;
        do_reset(1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        x0 = bus.pos_x;
        for (int t = 1; t <= 24; t++) begin
            // Presses during FALL and on the landing tick must be ignored.
            tick(1'b0, 1'b1, (t == 15) || (t == 24));
            if (t == 15) begin
                checks++;
                if (bus.move_state !== FALL) begin
                    failures++;
                    $display("FAIL fall_press got st=%0d exp st=%0d", bus.move_state, FALL);
                end
            end
        end
        checks++;
        if (bus.move_state !== WALK || bus.pos_x !== x0 + 11'd48 || bus.pos_y !== 11'd400) begin
            failures++;
            $display("FAIL land_walk got st=%0d x=%0d y=%0d exp st=%0d x=%0d y=400",
                     bus.move_state, bus.pos_x, bus.pos_y, WALK, x0 + 11'd48);
        end
        tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.move_state !== WALK) begin
            failures++;
            $display("FAIL no_relaunch got st=%0d exp st=%0d", bus.move_state, WALK);
        end
    endtask

    task automatic test_reset_midair();
        logic [1:0]  s0;
        logic [10:0] x0, y0;
        logic        f0, g0;
        do_reset(1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 6; t++) tick(1'b0, 1'b0, 1'b1);
        do_reset(1'b1, 1'b1);
        checks++;
        if (bus.move_state !== IDLE || bus.pos_y !== 11'd400 || bus.pos_x !== 11'd296 || bus.grounded !== 1'b1) begin
            failures++;
            $display("FAIL midair_reset got st=%0d x=%0d y=%0d gnd=%0b exp st=0 x=296 y=400 gnd=1",
                     bus.move_state, bus.pos_x, bus.pos_y, bus.grounded);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.pos_y !== 11'd388) begin
            failures++;
            $display("FAIL relaunch_after_reset got y=%0d exp y=388", bus.pos_y);
        end
        // No frame_tick: nothing may move even with buttons toggling.
        s0 = bus.move_state; x0 = bus.pos_x; y0 = bus.pos_y; f0 = bus.facing_left; g0 = bus.grounded;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            bus.btn_left  = 1'($urandom_range(0, 1));
            bus.btn_right = 1'($urandom_range(0, 1));
            bus.btn_jump  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            checks++;
            if (bus.move_state !== s0 || bus.pos_x !== x0 || bus.pos_y !== y0 ||
                bus.facing_left !== f0 || bus.grounded !== g0) begin
                failures++;
                $display("FAIL hold_no_tick c=%0d got st=%0d x=%0d y=%0d exp st=%0d x=%0d y=%0d",
                         c, bus.move_state, bus.pos_x, bus.pos_y, s0, x0, y0);
            end
        end
        // The model's jump_prev still holds the last ticked value (1).
        for (int t = 0; t < 30; t++) tick(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        do_reset(1'b0, 1'b0);
        for (int t = 0; t < 400; t++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    endtask

    initial begin
        reset               = 1'b1;
        bus.frame_tick      = 1'b0;
        bus.btn_left        = 1'b0;
        bus.btn_right       = 1'b0;
        bus.btn_jump        = 1'b0;
        edge_bus.frame_tick = 1'b0;
        edge_bus.btn_left   = 1'b0;
        edge_bus.btn_right  = 1'b0;
        edge_bus.btn_jump   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        test_reset();
        test_walk();
        test_left_edge();
        test_jump();
        test_jump_walk();
        test_reset_midair();
        test_random();

        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d pending exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
